// File: rtl/bcd_seq_pkg.sv
// Shared types and helpers for the BCD key sequencer.
// Provides bcd_t, seq_state_t, MAX_KEYS and the rotation-pointer wrap rule.
package bcd_seq_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic {
        IDLE,
        EMIT
    } seq_state_t;

    localparam int MAX_KEYS = 9;

    // Step one key below the emitted code; key 1 wraps to the top key.
    function automatic bcd_t next_ptr(bcd_t code, bcd_t top);
        return (code <= 4'd1) ? top : code - 4'd1;
    endfunction

endpackage

// File: rtl/bcd_priority_pick.sv
// Combinational key picker: vec (pending keys), start (rotation pointer,
// only with BCD_SEQ_ROUND_ROBIN_EN) -> sel, any_set, only_one.
module bcd_priority_pick
    import bcd_seq_pkg::*;
#(
    parameter int NUM_KEYS = 9
) (
    input  logic [NUM_KEYS:1] vec,
`ifdef BCD_SEQ_ROUND_ROBIN_EN
    input  bcd_t              start,
`endif
    output bcd_t              sel,
    output logic              any_set,
    output logic              only_one
);

    assign any_set  = |vec;
    assign only_one = ($countones(vec) <= 1);

`ifdef BCD_SEQ_ROUND_ROBIN_EN
    int best;
    int dist;

    // Downward distance from start to key j, modulo NUM_KEYS;
    // the set key with the smallest distance wins.
    always_comb begin
        sel  = '0;
        best = NUM_KEYS;
        dist = 0;
        for (int j = 1; j <= NUM_KEYS; j++) begin
            if (int'(start) >= j)
                dist = int'(start) - j;
            else
                dist = int'(start) - j + NUM_KEYS;
            if (vec[j] && dist < best) begin
                best = dist;
                sel  = bcd_t'(j);
            end
        end
    end
`else
    always_comb begin
        sel = '0;
        for (int j = 1; j <= NUM_KEYS; j++) begin
            if (vec[j])
                sel = bcd_t'(j);
        end
    end
`endif

endmodule

// File: rtl/bcd_key_sequencer.sv
// Snapshot a multi-hot key vector and stream one BCD code per set key.
// Ports: clk, rstN, key_in/key_valid/key_ready (snapshot in),
// bcd_out/bcd_valid/bcd_last/out_ready (code stream), overrun (pulse).
// Option: BCD_SEQ_ROUND_ROBIN_EN enables a rotating start pointer.
module bcd_key_sequencer
    import bcd_seq_pkg::*;
#(
    parameter int NUM_KEYS  = 9,
    parameter bit EMIT_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic [NUM_KEYS:1] key_in,
    input  logic              key_valid,
    output logic              key_ready,
    output logic [3:0]        bcd_out,
    output logic              bcd_valid,
    output logic              bcd_last,
    input  logic              out_ready,
    output logic              overrun
);

    if (NUM_KEYS < 1 || NUM_KEYS > MAX_KEYS) begin : g_bad_keys
        $error("NUM_KEYS out of range");
    end

    localparam bcd_t TOP = bcd_t'(NUM_KEYS);

    seq_state_t        state;
    seq_state_t        state_nx;
    logic [NUM_KEYS:1] pending;
    logic [NUM_KEYS:1] clr_mask;
    logic [NUM_KEYS:1] pick_vec;
    bcd_t              out_q;
    bcd_t              pick_sel;
    logic              last_q;
    logic              ovr_q;
    logic              pick_any;
    logic              pick_one;
    logic              load;
    logic              xfer;

    // A single picker serves both the fresh snapshot (IDLE) and the
    // pending set minus the code being transferred (EMIT), so the next
    // code is registered on the same edge as the transfer.
    always_comb begin
        clr_mask = '0;
        for (int k = 1; k <= NUM_KEYS; k++)
            clr_mask[k] = (out_q == bcd_t'(k));
        pick_vec = (state == IDLE) ? key_in : (pending & ~clr_mask);
    end

`ifdef BCD_SEQ_ROUND_ROBIN_EN
    bcd_t rp_q;
    bcd_t pick_start;

    assign pick_start = (state == IDLE) ? rp_q : next_ptr(out_q, TOP);
`endif

    bcd_priority_pick #(
        .NUM_KEYS (NUM_KEYS)
    ) u_pick (
        .vec      (pick_vec),
`ifdef BCD_SEQ_ROUND_ROBIN_EN
        .start    (pick_start),
`endif
        .sel      (pick_sel),
        .any_set  (pick_any),
        .only_one (pick_one)
    );

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        xfer     = 1'b0;
        case (state)
            IDLE: begin
                if (key_valid && (pick_any || EMIT_ZERO)) begin
                    state_nx = EMIT;
                    load     = 1'b1;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    xfer = 1'b1;
                    if (last_q)
                        state_nx = IDLE;
                    else
                        load = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            pending <= '0;
            out_q   <= '0;
            last_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ovr_q <= key_valid && (state == EMIT);
            if (load) begin
                pending <= pick_vec;
                out_q   <= pick_sel;
                last_q  <= pick_one;
            end else if (xfer) begin
                pending <= '0;
                out_q   <= '0;
                last_q  <= 1'b0;
            end
        end
    end

`ifdef BCD_SEQ_ROUND_ROBIN_EN
    // Empty-snapshot transfers (code 0) leave the pointer alone.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)
            rp_q <= TOP;
        else if (xfer && out_q != 4'd0)
            rp_q <= next_ptr(out_q, TOP);
    end
`endif

    assign key_ready = (state == IDLE);
    assign bcd_valid = (state == EMIT);
    assign bcd_out   = out_q;
    assign bcd_last  = last_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_bcd_key_sequencer.sv
// Scoreboard bench for bcd_key_sequencer (NUM_KEYS=9, EMIT_ZERO=1).
// Stimulus pushes expected codes; a negedge monitor pops on each transfer.
module tb_bcd_key_sequencer;

    logic       clk = 1'b0;
    logic       rstN;
    logic [9:1] key_in;
    logic       key_valid;
    logic       key_ready;
    logic [3:0] bcd_out;
    logic       bcd_valid;
    logic       bcd_last;
    logic       out_ready;
    logic       overrun;

    typedef struct {
        logic [3:0] code;
        logic       last;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    bcd_key_sequencer dut (
        .clk       (clk),
        .rstN      (rstN),
        .key_in    (key_in),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .bcd_out   (bcd_out),
        .bcd_valid (bcd_valid),
        .bcd_last  (bcd_last),
        .out_ready (out_ready),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rstN === 1'b1 && bcd_valid === 1'b1 && out_ready === 1'b1) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_code: got %0d expected none",
                         bcd_out);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("code", 32'(bcd_out), 32'(e.code));
                chk("last", 32'(bcd_last), 32'(e.last));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] code, input logic last);
        exp_t e;
        e.code = code;
        e.last = last;
        q.push_back(e);
    endtask

    task automatic send(input logic [9:1] v);
        key_in    = v;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        key_in    = '0;
    endtask

    task automatic drain(input string name, input int exp_cycles);
        int c = 0;
        while ((q.size() != 0 || key_ready !== 1'b1) && c < 50) begin
            tick();
            c++;
        end
        if (c >= 50) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: got %0d queued expected 0",
                     name, q.size());
        end else begin
            chk({name, "_cycles"}, 32'(c), 32'(exp_cycles));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        rstN      = 1'b0;
        key_in    = '0;
        key_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rst_key_ready", 32'(key_ready), 1);
        chk("rst_bcd_valid", 32'(bcd_valid), 0);
        chk("rst_bcd_last", 32'(bcd_last), 0);
        chk("rst_bcd_out", 32'(bcd_out), 0);
        chk("rst_overrun", 32'(overrun), 0);
        tick();
        tick();
        @(negedge clk);
        rstN = 1'b1;
        tick();

        // Empty snapshot -> single code 0 with last.
        push(4'd0, 1'b1);
        send(9'b000000000);
        chk("zero_valid", 32'(bcd_valid), 1);
        drain("zero", 1);
        chk("zero_key_ready", 32'(key_ready), 1);

        // Keys 9,5,2 back to back.
        push(4'd9, 1'b0);
        push(4'd5, 1'b0);
        push(4'd2, 1'b1);
        send(9'b100010010);
        chk("lat_valid", 32'(bcd_valid), 1);
        chk("lat_key_ready", 32'(key_ready), 0);
        chk("lat_code", 32'(bcd_out), 9);
        drain("seq952", 3);

        // Same snapshot again (rotating pointer wraps to the same order).
        push(4'd9, 1'b0);
        push(4'd5, 1'b0);
        push(4'd2, 1'b1);
        send(9'b100010010);
        drain("seq952_again", 3);

        // Backpressure holds the first code stable.
        out_ready = 1'b0;
        push(4'd9, 1'b0);
        push(4'd5, 1'b0);
        push(4'd2, 1'b1);
        send(9'b100010010);
        for (int i = 0; i < 3; i++) begin
            chk("stall_code", 32'(bcd_out), 9);
            chk("stall_valid", 32'(bcd_valid), 1);
            chk("stall_last", 32'(bcd_last), 0);
            tick();
        end
        out_ready = 1'b1;
        drain("stall", 3);

        // Snapshot request during EMIT is ignored and flagged.
        push(4'd9, 1'b0);
        push(4'd5, 1'b0);
        push(4'd2, 1'b1);
        send(9'b100010010);
        key_in    = 9'b000000001;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        key_in    = '0;
        chk("overrun_pulse", 32'(overrun), 1);
        tick();
        chk("overrun_clear", 32'(overrun), 0);
        drain("overrun", 1);
        tick();
        tick();
        chk("overrun_no_key1", 32'(bcd_valid), 0);

        // Lowest key alone.
        push(4'd1, 1'b1);
        send(9'b000000001);
        drain("key1", 1);

        // Key 9 alone, then keys 5 and 1.
        push(4'd9, 1'b1);
        send(9'b100000000);
        drain("key9", 1);
        push(4'd5, 1'b0);
        push(4'd1, 1'b1);
        send(9'b000010001);
        drain("seq51", 2);

        // Leaves the rotating pointer just above key 1.
        push(4'd9, 1'b0);
        push(4'd5, 1'b0);
        push(4'd2, 1'b1);
        send(9'b100010010);
        drain("seq952_pre", 3);

        // Keys 9 and 1: order depends on the scheduling mode.
`ifdef BCD_SEQ_ROUND_ROBIN_EN
        push(4'd1, 1'b0);
        push(4'd9, 1'b1);
`else
        push(4'd9, 1'b0);
        push(4'd1, 1'b1);
`endif
        send(9'b100000001);
        drain("seq91", 2);

        // Reset after code 9 aborts the snapshot.
        push(4'd9, 1'b0);
        push(4'd5, 1'b0);
        push(4'd2, 1'b1);
        send(9'b100010010);
        tick();
        rstN = 1'b0;
        #1;
        chk("abort_valid", 32'(bcd_valid), 0);
        chk("abort_key_ready", 32'(key_ready), 1);
        chk("abort_out", 32'(bcd_out), 0);
        q.delete();
        tick();
        @(negedge clk);
        rstN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("abort_quiet", 32'(bcd_valid), 0);
        end

        // Normal operation after reset.
        push(4'd9, 1'b0);
        push(4'd5, 1'b0);
        push(4'd2, 1'b1);
        send(9'b100010010);
        drain("post_reset", 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
